// File: rtl/ecc_link_pkg.sv
// Shared definitions for the ECC link controller slice.
//   BYTE_W        : width of the channel data byte
//   DEF_CH_LAT    : default channel latency (launch to valid result)
//   DEF_MAX_RETRY : default retransmissions per byte after an uncorrectable error
//   state_t       : controller FSM states
package ecc_link_pkg;

  localparam int BYTE_W        = 8;
  localparam int DEF_CH_LAT    = 2;
  localparam int DEF_MAX_RETRY = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DELIVER = 3'd4
  } state_t;

endpackage

// File: rtl/ecc_link_controller_sat_counter.sv
// Saturating event counter used for link-quality statistics.
// Ports:
//   clk   : clock, rising edge
//   clr   : synchronous clear, wins over a same-cycle inc
//   inc   : count one event
//   count : current value, sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ecc_link_controller.sv
// Sequencing controller for the Hamming-protected byte channel. Accepts one
// byte at a time from the source, launches it into the channel, samples the
// decoded result CH_LAT cycles later, and delivers, retransmits or drops it.
// Ports:
//   clk, rst                 : clock and synchronous active-high reset
//   in_data/in_valid/in_ready: upstream byte handshake
//   out_data/out_valid/out_ready: downstream byte handshake
//   ch_data_in, ch_launch    : byte and one-cycle launch pulse into the channel
//   ch_data_out, ch_err_det, ch_err_cor: channel result, sampled in CHECK
//   drop                     : one-cycle pulse when a byte is discarded
//   busy                     : controller is not IDLE
//   clr_cnt                  : synchronous clear of the statistics counters
//   cnt_corrected/cnt_retry/cnt_drop: saturating statistics counters
//   dbg_state                : current FSM state for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A source holds its byte until accepted; out_valid/out_data stay
// stable until out_ready is seen.
module ecc_link_controller
  import ecc_link_pkg::*;
#(
  parameter int CH_LAT    = DEF_CH_LAT,
  parameter int MAX_RETRY = DEF_MAX_RETRY,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] ch_data_in,
  output logic              ch_launch,
  input  logic [BYTE_W-1:0] ch_data_out,
  input  logic              ch_err_det,
  input  logic              ch_err_cor,
  output logic              drop,
  output logic              busy,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  cnt_corrected,
  output logic [CNT_W-1:0]  cnt_retry,
  output logic [CNT_W-1:0]  cnt_drop,
  output state_t            dbg_state
);

  localparam logic [3:0] WAIT_LOAD = 4'(CH_LAT - 1);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

  state_t            state_q, state_d;
  logic [BYTE_W-1:0] hold_q;
  logic [BYTE_W-1:0] out_data_q;
  logic [3:0]        wait_q;
  logic [2:0]        retry_q;
  logic              drop_q;

  logic capture;
  logic latch_out;
  logic inc_cor;
  logic inc_retry;
  logic inc_drop;
  logic cnt_clr;

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    latch_out = 1'b0;
    inc_cor   = 1'b0;
    inc_retry = 1'b0;
    inc_drop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          capture = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // The counter reaches zero on this edge, so CHECK lands CH_LAT
        // cycles after the launch cycle.
        if (wait_q <= 4'd1) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // A correction flag without a detection flag is treated as clean.
        if (!ch_err_det || ch_err_cor) begin
          latch_out = 1'b1;
          inc_cor   = ch_err_det;
          state_d   = ST_DELIVER;
        end else if (retry_q < RETRY_MAX) begin
          inc_retry = 1'b1;
          state_d   = ST_SEND;
        end else begin
          inc_drop  = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_DELIVER: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      out_data_q <= '0;
      wait_q     <= '0;
      retry_q    <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      // Registered so the pulse appears with the FSM already back in IDLE.
      drop_q  <= inc_drop;
      if (capture) begin
        hold_q  <= in_data;
        retry_q <= '0;
      end else if (inc_retry) begin
        retry_q <= retry_q + 1'b1;
      end
      if (state_q == ST_SEND) begin
        wait_q <= WAIT_LOAD;
      end else if (state_q == ST_WAIT) begin
        wait_q <= wait_q - 1'b1;
      end
      if (latch_out) begin
        out_data_q <= ch_data_out;
      end
    end
  end

  assign in_ready   = (state_q == ST_IDLE) && !rst;
  assign out_valid  = (state_q == ST_DELIVER);
  assign out_data   = out_data_q;
  assign ch_launch  = (state_q == ST_SEND);
  assign ch_data_in = hold_q;
  assign drop       = drop_q;
  assign busy       = (state_q != ST_IDLE);
  assign dbg_state  = state_q;

  // Reset clears the counters through the clear path, which also discards
  // any increment from a byte aborted by that reset.
  assign cnt_clr = rst || clr_cnt;

  sat_counter #(.CNT_W(CNT_W)) u_cnt_corrected (
    .clk   (clk),
    .clr   (cnt_clr),
    .inc   (inc_cor),
    .count (cnt_corrected)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_retry (
    .clk   (clk),
    .clr   (cnt_clr),
    .inc   (inc_retry),
    .count (cnt_retry)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_drop (
    .clk   (clk),
    .clr   (cnt_clr),
    .inc   (inc_drop),
    .count (cnt_drop)
  );

endmodule

// File: tb/tb_ecc_link_controller.sv
// Directed testbench for ecc_link_controller. The bench plays the channel by
// driving ch_data_out/ch_err_det/ch_err_cor, and checks timing, data and
// counters against hand-computed values.
module tb_ecc_link_controller;
  import ecc_link_pkg::*;

  localparam int CH_LAT    = 2;
  localparam int MAX_RETRY = 3;
  localparam int CNT_W     = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]       in_data = 8'h00;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [7:0]       ch_data_in;
  logic             ch_launch;
  logic [7:0]       ch_data_out = 8'h00;
  logic             ch_err_det = 1'b0;
  logic             ch_err_cor = 1'b0;
  logic             drop;
  logic             busy;
  logic             clr_cnt = 1'b0;
  logic [CNT_W-1:0] cnt_corrected;
  logic [CNT_W-1:0] cnt_retry;
  logic [CNT_W-1:0] cnt_drop;
  state_t           dbg_state;

  ecc_link_controller #(
    .CH_LAT    (CH_LAT),
    .MAX_RETRY (MAX_RETRY),
    .CNT_W     (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .ch_data_in    (ch_data_in),
    .ch_launch     (ch_launch),
    .ch_data_out   (ch_data_out),
    .ch_err_det    (ch_err_det),
    .ch_err_cor    (ch_err_cor),
    .drop          (drop),
    .busy          (busy),
    .clr_cnt       (clr_cnt),
    .cnt_corrected (cnt_corrected),
    .cnt_retry     (cnt_retry),
    .cnt_drop      (cnt_drop),
    .dbg_state     (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // monitor: cycle stamp of each launch, drop pulses and output-valid cycles
  int cyc        = 0;
  int launch_cyc[$];
  int drop_seen  = 0;
  int ov_seen    = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ch_launch) launch_cyc.push_back(cyc);
    if (drop) drop_seen <= drop_seen + 1;
    if (out_valid) ov_seen <= ov_seen + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_channel(input logic [7:0] d, input logic det, input logic cor);
    ch_data_out = d;
    ch_err_det  = det;
    ch_err_cor  = cor;
  endtask

  // Returns one cycle after the accepting edge (the SEND cycle).
  task automatic drive_byte(input logic [7:0] d, output bit ok);
    in_data  = d;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (out_valid) ok = 1'b1;
      else step();
    end
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic clear_counters();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_checks++; if ({busy, out_valid, ch_launch, drop} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {busy, out_valid, ch_launch, drop}); end
    n_checks++; if ({out_data, ch_data_in} !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h expected 0000", {out_data, ch_data_in}); end
    n_checks++; if ({cnt_corrected, cnt_retry, cnt_drop} !== 12'h000) begin n_fail++; $display("FAIL reset_counters: got %h expected 000", {cnt_corrected, cnt_retry, cnt_drop}); end
    rst = 1'b0;
    step();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
    n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_clean();
    set_channel(8'hAA, 1'b0, 1'b0);
    in_data  = 8'hAA;
    in_valid = 1'b1;
    // cycle 0
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL clean_c0_ready: got %b expected 1", in_ready); end
    step();
    in_valid = 1'b0;
    // cycle 1
    n_checks++; if (ch_launch !== 1'b1) begin n_fail++; $display("FAIL clean_c1_launch: got %b expected 1", ch_launch); end
    n_checks++; if (ch_data_in !== 8'hAA) begin n_fail++; $display("FAIL clean_c1_ch_data: got %h expected aa", ch_data_in); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL clean_c1_ready: got %b expected 0", in_ready); end
    step();
    // cycle 2
    n_checks++; if (ch_launch !== 1'b0 || dbg_state !== ST_WAIT) begin n_fail++; $display("FAIL clean_c2_wait: got launch=%b state=%0d expected launch=0 state=%0d", ch_launch, dbg_state, ST_WAIT); end
    step();
    // cycle 3
    n_checks++; if (out_valid !== 1'b0 || dbg_state !== ST_CHECK) begin n_fail++; $display("FAIL clean_c3_check: got ov=%b state=%0d expected ov=0 state=%0d", out_valid, dbg_state, ST_CHECK); end
    step();
    // cycle 4
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clean_c4_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_data !== 8'hAA) begin n_fail++; $display("FAIL clean_c4_data: got %h expected aa", out_data); end
    take_out();
    // cycle 5
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL clean_c5_idle: got ready=%b ov=%b expected ready=1 ov=0", in_ready, out_valid); end
    n_checks++; if ({cnt_corrected, cnt_retry, cnt_drop} !== 12'h000) begin n_fail++; $display("FAIL clean_counters: got %h expected 000", {cnt_corrected, cnt_retry, cnt_drop}); end
  endtask

  task automatic test_corrected();
    bit ok;
    int base;
    base = launch_cyc.size();
    set_channel(8'hCC, 1'b1, 1'b1);
    drive_byte(8'h3C, ok);
    wait_out(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL corr_timeout: got no out_valid expected out_valid"); end
    n_checks++; if (out_data !== 8'hCC) begin n_fail++; $display("FAIL corr_data: got %h expected cc", out_data); end
    n_checks++; if (cnt_corrected !== 4'd1 || cnt_retry !== 4'd0) begin n_fail++; $display("FAIL corr_counts: got cor=%0d retry=%0d expected cor=1 retry=0", cnt_corrected, cnt_retry); end
    n_checks++; if (launch_cyc.size() - base != 1) begin n_fail++; $display("FAIL corr_launches: got %0d expected 1", launch_cyc.size() - base); end
    take_out();
    // correction flag alone is treated as a clean result
    set_channel(8'h55, 1'b0, 1'b1);
    drive_byte(8'h55, ok);
    wait_out(ok);
    n_checks++; if (!ok || out_data !== 8'h55) begin n_fail++; $display("FAIL cor_only_data: got ok=%0d data=%h expected ok=1 data=55", ok, out_data); end
    n_checks++; if (cnt_corrected !== 4'd1) begin n_fail++; $display("FAIL cor_only_count: got %0d expected 1", cnt_corrected); end
    take_out();
  endtask

  task automatic test_retry_success();
    bit ok;
    int base;
    int gap;
    clear_counters();
    base = launch_cyc.size();
    set_channel(8'h00, 1'b1, 1'b0);
    drive_byte(8'hF0, ok);
    // SEND in cycle 1, CHECK in cycle 3 sees the error; switch to clean after it
    step();
    step();
    step();
    set_channel(8'hF0, 1'b0, 1'b0);
    wait_out(ok);
    n_checks++; if (!ok || out_data !== 8'hF0) begin n_fail++; $display("FAIL retry_data: got ok=%0d data=%h expected ok=1 data=f0", ok, out_data); end
    n_checks++; if (cnt_retry !== 4'd1) begin n_fail++; $display("FAIL retry_count: got %0d expected 1", cnt_retry); end
    gap = (launch_cyc.size() >= base + 2) ? launch_cyc[base+1] - launch_cyc[base] : -1;
    n_checks++; if (launch_cyc.size() - base != 2 || gap != CH_LAT + 1) begin n_fail++; $display("FAIL retry_launch_gap: got n=%0d gap=%0d expected n=2 gap=%0d", launch_cyc.size() - base, gap, CH_LAT + 1); end
    take_out();
  endtask

  task automatic test_drop();
    bit ok;
    bit found;
    int base, d0, ov0, k;
    clear_counters();
    base = launch_cyc.size();
    d0   = drop_seen;
    ov0  = ov_seen;
    set_channel(8'h00, 1'b1, 1'b0);
    drive_byte(8'h5A, ok);
    found = 1'b0;
    k = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (drop) found = 1'b1;
      else begin step(); k++; end
    end
    n_checks++; if (!found || k != (CH_LAT + 1) * (MAX_RETRY + 1)) begin n_fail++; $display("FAIL drop_timing: got found=%0d cycles=%0d expected found=1 cycles=%0d", found, k, (CH_LAT + 1) * (MAX_RETRY + 1)); end
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got ready=%b busy=%b expected ready=1 busy=0", in_ready, busy); end
    n_checks++; if (cnt_retry !== 4'd3 || cnt_drop !== 4'd1) begin n_fail++; $display("FAIL drop_counts: got retry=%0d drop=%0d expected retry=3 drop=1", cnt_retry, cnt_drop); end
    step();
    n_checks++; if (drop !== 1'b0 || drop_seen - d0 != 1) begin n_fail++; $display("FAIL drop_pulse: got drop=%b pulses=%0d expected drop=0 pulses=1", drop, drop_seen - d0); end
    n_checks++; if (launch_cyc.size() - base != MAX_RETRY + 1) begin n_fail++; $display("FAIL drop_launches: got %0d expected %0d", launch_cyc.size() - base, MAX_RETRY + 1); end
    n_checks++; if (ov_seen != ov0) begin n_fail++; $display("FAIL drop_no_output: got %0d valid cycles expected 0", ov_seen - ov0); end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    int d0;
    d0 = drop_seen;
    set_channel(8'h00, 1'b1, 1'b0);
    drive_byte(8'h77, ok);
    step();
    n_checks++; if (dbg_state !== ST_WAIT) begin n_fail++; $display("FAIL rstwait_state: got %0d expected %0d", dbg_state, ST_WAIT); end
    rst = 1'b1;
    step();
    n_checks++; if ({busy, out_valid, ch_launch, drop, in_ready} !== 5'b00000) begin n_fail++; $display("FAIL rstwait_flags: got %b expected 00000", {busy, out_valid, ch_launch, drop, in_ready}); end
    n_checks++; if ({out_data, ch_data_in} !== 16'h0000) begin n_fail++; $display("FAIL rstwait_data: got %h expected 0000", {out_data, ch_data_in}); end
    n_checks++; if ({cnt_corrected, cnt_retry, cnt_drop} !== 12'h000) begin n_fail++; $display("FAIL rstwait_counters: got %h expected 000", {cnt_corrected, cnt_retry, cnt_drop}); end
    rst = 1'b0;
    step();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstwait_ready: got %b expected 1", in_ready); end
    for (int i = 0; i < 6; i++) step();
    n_checks++; if (drop_seen != d0 || cnt_drop !== 4'd0) begin n_fail++; $display("FAIL rstwait_no_drop: got pulses=%0d cnt=%0d expected 0 0", drop_seen - d0, cnt_drop); end
  endtask

  task automatic test_backpressure();
    bit ok;
    set_channel(8'h0F, 1'b0, 1'b0);
    drive_byte(8'h0F, ok);
    wait_out(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: got no out_valid expected out_valid"); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h0F) begin n_fail++; $display("FAIL bp_hold_%0d: got ov=%b data=%h expected ov=1 data=0f", i, out_valid, out_data); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_%0d: got %b expected 0", i, in_ready); end
      step();
    end
    take_out();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got ready=%b ov=%b expected ready=1 ov=0", in_ready, out_valid); end
  endtask

  task automatic test_counters();
    bit ok;
    clear_counters();
    set_channel(8'hC3, 1'b1, 1'b1);
    for (int i = 0; i < 17; i++) begin
      drive_byte(8'hC3, ok);
      wait_out(ok);
      take_out();
    end
    n_checks++; if (cnt_corrected !== 4'hF) begin n_fail++; $display("FAIL sat_hold: got %h expected f", cnt_corrected); end
    // clear in the CHECK cycle of a corrected byte wins over the increment
    drive_byte(8'hC3, ok);
    step();
    step();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    n_checks++; if (cnt_corrected !== 4'd0) begin n_fail++; $display("FAIL clr_priority: got %0d expected 0", cnt_corrected); end
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hC3) begin n_fail++; $display("FAIL clr_fsm_unaffected: got ov=%b data=%h expected ov=1 data=c3", out_valid, out_data); end
    take_out();
    drive_byte(8'hC3, ok);
    wait_out(ok);
    take_out();
    n_checks++; if (cnt_corrected !== 4'd1) begin n_fail++; $display("FAIL clr_resume: got %0d expected 1", cnt_corrected); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_corrected();
    test_retry_success();
    test_drop();
    test_reset_mid_wait();
    test_backpressure();
    test_counters();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ecc_link_controller.md
# ecc_link_controller

Sequencing controller that feeds the Hamming-protected 8-bit data channel one byte at a time and checks each result. It takes bytes from an upstream source over a valid/ready handshake and launches each byte into the channel. After a fixed channel latency it samples the decoded byte and the error flags. It forwards clean or corrected bytes downstream, retransmits on uncorrectable errors up to a retry limit, and keeps saturating event counters for link-quality monitoring.

## Interface
Parameters:
- CH_LAT, 2: cycles from channel launch to valid channel result; legal range 2..15.
- MAX_RETRY, 3: retransmissions allowed per byte after an uncorrectable error; legal range 0..7.
- CNT_W, 16: width of each statistics counter.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  8  byte from source.
- in_valid  input  1  source has a byte.
- in_ready  output  1  controller accepts a byte this cycle.
- out_data  output  8  delivered byte.
- out_valid  output  1  delivered byte is valid.
- out_ready  input  1  sink accepts the byte.
- ch_data_in  output  8  byte driven into the channel; held stable from launch until CHECK.
- ch_launch  output  1  one-cycle pulse marking a channel launch.
- ch_data_out  input  8  decoded byte from the channel.
- ch_err_det  input  1  channel detected an error.
- ch_err_cor  input  1  channel corrected a single-bit error.
- drop  output  1  one-cycle pulse: byte discarded after retries were exhausted.
- busy  output  1  high in any state other than IDLE.
- clr_cnt  input  1  synchronous clear of all counters.
- cnt_corrected  output  CNT_W  count of corrected bytes.
- cnt_retry  output  CNT_W  count of retransmissions.
- cnt_drop  output  CNT_W  count of dropped bytes.

## Operation
- States: IDLE, SEND, WAIT, CHECK, DELIVER.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture in_data into the holding register, set retry_cnt=0, and go to SEND.
- SEND:
  - ch_launch=1 for this cycle, with ch_data_in = holding register.
  - Load the wait counter with CH_LAT-1 and go to WAIT.
- WAIT: decrement the counter each cycle; go to CHECK when it reaches 0.
- CHECK (sample ch_* inputs this cycle):
  - !ch_err_det: latch ch_data_out into out_data and go to DELIVER.
  - ch_err_det&&ch_err_cor: latch ch_data_out, increment cnt_corrected, go to DELIVER.
  - ch_err_det&&!ch_err_cor with retry_cnt<MAX_RETRY: retry_cnt+1, increment cnt_retry, go to SEND.
  - ch_err_det&&!ch_err_cor with retry_cnt==MAX_RETRY: pulse drop, increment cnt_drop, go to IDLE; no output is produced.
- DELIVER:
  - out_valid=1 and out_data held stable until out_ready.
  - On handshake, go to IDLE.
- ch_err_cor without ch_err_det is treated as clean.
- Counters saturate at all-ones and never wrap.
- clr_cnt zeroes all counters. It takes priority over a same-cycle increment and does not affect the state machine.
- One byte is in flight at a time; in_ready is low in every state except IDLE.

## Timing
- Reset (rst high at a clock edge):
  - State goes to IDLE.
  - in_ready=0 while rst is high; it is 1 from the first cycle after rst deasserts.
  - out_valid=0, out_data=0, ch_data_in=0, ch_launch=0, drop=0, busy=0.
  - All counters=0, retry_cnt=0.
- Reset in any state aborts the in-flight byte silently; no drop pulse and no counter update.
- Clean-path latency (input handshake in cycle 0):
  - ch_launch in cycle 1.
  - CHECK in cycle CH_LAT+1.
  - out_valid first high in cycle CH_LAT+2.
- Each retry adds CH_LAT+1 cycles.
- After the output handshake in cycle n, in_ready=1 in cycle n+1.
- in_valid while busy is ignored; the source must hold its byte.
- out_valid never drops without out_ready.
- drop is asserted in the cycle after the final CHECK, with state already IDLE; in_ready is 1 in that same cycle.

## Structure
- Shared package ecc_link_pkg:
  - State enum type.
  - Byte width constant (8).
  - Default CH_LAT and MAX_RETRY constants.
- Sub-module sat_counter: CNT_W-bit saturating counter with inc and clr (clr priority). Instantiated three times.
- The FSM, wait counter, retry counter and holding register live in ecc_link_controller.

## Test plan
- Clean byte, CH_LAT=2: in_data=8'hAA accepted in cycle 0 -> ch_launch in cycle 1 with ch_data_in=8'hAA; out_valid in cycle 4 with out_data=8'hAA; all counters 0.
- Corrected byte: channel returns 8'hCC with det=1, cor=1 -> out_data=8'hCC, cnt_corrected=1, no retry.
- Retry then success: first result det=1, cor=0, second result clean 8'hF0 -> two ch_launch pulses CH_LAT+1 cycles apart, cnt_retry=1, out_data=8'hF0.
- Persistent double error, MAX_RETRY=3: every result det=1, cor=0 -> 4 launches, cnt_retry=3, one drop pulse, cnt_drop=1, out_valid never asserted.
- Backpressure: out_ready held low for 5 cycles -> out_valid and out_data=8'h0F stable for those cycles; in_ready stays 0 until one cycle after the handshake.
- Reset mid-WAIT, followed by clr_cnt/saturation check:
  - rst during WAIT -> all outputs reach reset values the next cycle, and no drop pulse.
  - With cnt_corrected preset near all-ones by 2^CNT_W corrected events, it holds at all-ones.
